cp0_regfile: RTL and testbench

Coprocessor-0 register file that consumes the except_req bundle produced by the exception-arbitration logic and publishes the cp0_regs bundle and interrupt_req vector back to it. It commits exceptions and ERET, serves MFC0 and MTC0, runs the Count/Compare timer, and latches hardware interrupt lines. It sits beside the writeback stage; all architectural CP0 state lives here.

---
 rtl/cp0_regfile.sv | 154 +++++++++++++++
 tb/tb_cp0_regfile.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/cp0_regfile.sv
// Coprocessor-0 register file: exception/ERET commit, MFC0/MTC0, Count/Compare timer
// and hardware interrupt sampling. Shared bundle types live in the package below.
package cp0_regfile_pkg;
  typedef struct packed {
    logic        valid;
    logic        eret;
    logic [4:0]  code;
    logic [31:0] extra;
    logic [31:0] pc;
    logic        delayslot;
  } except_req_t;

  typedef struct packed {
    logic [31:0] badvaddr;
    logic [31:0] count;
    logic [31:0] compare;
    logic [31:0] status;
    logic [31:0] cause;
    logic [31:0] epc;
    logic [31:0] ebase;
  } cp0_regs_t;

  localparam logic [4:0] EXC_MOD  = 5'd1;
  localparam logic [4:0] EXC_TLBL = 5'd2;
  localparam logic [4:0] EXC_TLBS = 5'd3;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
endpackage

module cp0_regfile
  import cp0_regfile_pkg::*;
#(
  parameter int          COUNT_DIV = 2,
  parameter logic [31:0] EBASE_RST = 32'h8000_0000,
  parameter logic [31:0] PRID_VAL  = 32'h0001_8000
) (
  input  logic        clk,
  input  logic        rst,
  input  except_req_t except_req,
  input  logic        wr_en,
  input  logic [4:0]  wr_addr,
  input  logic [2:0]  wr_sel,
  input  logic [31:0] wr_data,
  input  logic [4:0]  rd_addr,
  input  logic [2:0]  rd_sel,
  output logic [31:0] rd_data,
  input  logic [5:0]  int_in,
  output cp0_regs_t   cp0_regs,
  output logic [7:0]  interrupt_req,
  output logic        timer_int
);
  localparam logic [31:0] STATUS_MASK = 32'h1040_FF03;
  localparam logic [31:0] STATUS_RST  = 32'h0040_0000;

  logic [31:0] badvaddr, count, compare, status, cause, epc, ebase;
  logic        div;

  logic exc, eret, bad_addr_exc;
  logic we_count, we_compare, we_status, we_cause, we_epc, we_ebase;
  logic tick, timer_next;

  always_comb begin
    exc          = except_req.valid && !except_req.eret;
    eret         = except_req.valid && except_req.eret;
    bad_addr_exc = (except_req.code == EXC_ADEL) || (except_req.code == EXC_ADES) ||
                   (except_req.code == EXC_TLBL) || (except_req.code == EXC_TLBS) ||
                   (except_req.code == EXC_MOD);
    we_count     = wr_en && (wr_addr == 5'd9)  && (wr_sel == 3'd0);
    we_compare   = wr_en && (wr_addr == 5'd11) && (wr_sel == 3'd0);
    we_status    = wr_en && (wr_addr == 5'd12) && (wr_sel == 3'd0);
    we_cause     = wr_en && (wr_addr == 5'd13) && (wr_sel == 3'd0);
    we_epc       = wr_en && (wr_addr == 5'd14) && (wr_sel == 3'd0);
    we_ebase     = wr_en && (wr_addr == 5'd15) && (wr_sel == 3'd1);
    // With COUNT_DIV==2 the divider wraps on the cycle it is high.
    tick         = (COUNT_DIV == 1) ? 1'b1 : div;
    // Writing Compare acknowledges the timer even if a match happens this cycle.
    if (we_compare)
      timer_next = 1'b0;
    else if (count == compare)
      timer_next = 1'b1;
    else
      timer_next = timer_int;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      badvaddr  <= 32'h0;
      count     <= 32'h0;
      compare   <= 32'h0;
      status    <= STATUS_RST;
      cause     <= 32'h0;
      epc       <= 32'h0;
      ebase     <= EBASE_RST;
      timer_int <= 1'b0;
      div       <= 1'b0;
    end else begin
      div       <= (we_count || COUNT_DIV == 1) ? 1'b0 : ~div;
      count     <= we_count ? wr_data : (tick ? count + 32'd1 : count);
      timer_int <= timer_next;
      if (we_compare)
        compare <= wr_data;
      if (we_ebase)
        ebase <= {2'b10, wr_data[29:12], 12'h000};
      cause[15:10] <= {int_in[5] | timer_next, int_in[4:0]};

      // Exception and ERET own Status/Cause/EPC this cycle; MTC0 to them is dropped.
      if (exc) begin
        if (!status[1]) begin
          epc      <= except_req.delayslot ? except_req.pc - 32'd4 : except_req.pc;
          cause[31] <= except_req.delayslot;
        end
        status[1]  <= 1'b1;
        cause[6:2] <= except_req.code;
        if (bad_addr_exc)
          badvaddr <= except_req.extra;
      end else if (eret) begin
        status[1] <= 1'b0;
      end else begin
        if (we_status)
          status <= wr_data & STATUS_MASK;
        if (we_cause) begin
          cause[23]  <= wr_data[23];
          cause[9:8] <= wr_data[9:8];
        end
        if (we_epc)
          epc <= wr_data;
      end
    end
  end

  always_comb begin
    rd_data = 32'h0;
    case ({rd_addr, rd_sel})
      {5'd8,  3'd0}: rd_data = badvaddr;
      {5'd9,  3'd0}: rd_data = count;
      {5'd11, 3'd0}: rd_data = compare;
      {5'd12, 3'd0}: rd_data = status;
      {5'd13, 3'd0}: rd_data = cause;
      {5'd14, 3'd0}: rd_data = epc;
      {5'd15, 3'd0}: rd_data = PRID_VAL;
      {5'd15, 3'd1}: rd_data = ebase;
      default:       rd_data = 32'h0;
    endcase
  end

  assign interrupt_req     = cause[15:8] & status[15:8];
  assign cp0_regs.badvaddr = badvaddr;
  assign cp0_regs.count    = count;
  assign cp0_regs.compare  = compare;
  assign cp0_regs.status   = status;
  assign cp0_regs.cause    = cause;
  assign cp0_regs.epc      = epc;
  assign cp0_regs.ebase    = ebase;
endmodule

// File: tb/tb_cp0_regfile.sv
// Directed bench for cp0_regfile: expectations queued when stimulus is driven,
// popped and checked one cycle later against the registered outputs.
module tb_cp0_regfile;
  import cp0_regfile_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  except_req_t except_req;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [2:0]  wr_sel;
  logic [31:0] wr_data;
  logic [4:0]  rd_addr;
  logic [2:0]  rd_sel;
  logic [31:0] rd_data;
  logic [5:0]  int_in;
  cp0_regs_t   cp0_regs;
  logic [7:0]  interrupt_req;
  logic        timer_int;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       tag;
    int          which;
    logic [31:0] exp;
    logic [31:0] mask;
  } item_t;
  item_t sb[$];

  localparam int O_EPC = 0, O_CAUSE = 1, O_STATUS = 2, O_BADV = 3, O_COUNT = 4,
                 O_EBASE = 5, O_RD = 6, O_IRQ = 7, O_TIMER = 8, O_COMPARE = 9;

  cp0_regfile #(.COUNT_DIV(2), .EBASE_RST(32'h8000_0000), .PRID_VAL(32'h0001_8000)) dut (
    .clk(clk), .rst(rst), .except_req(except_req),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_sel(wr_sel), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_sel(rd_sel), .rd_data(rd_data),
    .int_in(int_in), .cp0_regs(cp0_regs), .interrupt_req(interrupt_req),
    .timer_int(timer_int)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] observe(input int which);
    case (which)
      O_EPC:     return cp0_regs.epc;
      O_CAUSE:   return cp0_regs.cause;
      O_STATUS:  return cp0_regs.status;
      O_BADV:    return cp0_regs.badvaddr;
      O_COUNT:   return cp0_regs.count;
      O_EBASE:   return cp0_regs.ebase;
      O_RD:      return rd_data;
      O_IRQ:     return {24'h0, interrupt_req};
      O_TIMER:   return {31'h0, timer_int};
      O_COMPARE: return cp0_regs.compare;
      default:   return 32'hxxxx_xxxx;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input int which, input logic [31:0] exp,
                      input logic [31:0] mask = 32'hFFFF_FFFF);
    sb.push_back('{tag, which, exp, mask});
  endtask

  task automatic drain();
    item_t it;
    while (sb.size() > 0) begin
      it = sb.pop_front();
      chk(it.tag, observe(it.which) & it.mask, it.exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    drain();
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [2:0] s, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_sel = s; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic raise(input logic [4:0] code, input logic [31:0] pc,
                       input logic ds, input logic [31:0] extra);
    except_req = '{valid: 1'b1, eret: 1'b0, code: code, extra: extra, pc: pc, delayslot: ds};
    step();
    except_req = '0;
  endtask

  task automatic mfc0(input string tag, input logic [4:0] a, input logic [2:0] s,
                      input logic [31:0] exp);
    rd_addr = a; rd_sel = s;
    #1;
    push(tag, O_RD, exp);
    drain();
  endtask

  initial begin
    int n;
    rst = 1'b0; except_req = '0; wr_en = 1'b0; wr_addr = '0; wr_sel = '0;
    wr_data = '0; rd_addr = '0; rd_sel = '0; int_in = '0;

    // Reset held for two cycles
    step();
    push("rst_status", O_STATUS, 32'h0040_0000);
    push("rst_ebase", O_EBASE, 32'h8000_0000);
    push("rst_count", O_COUNT, 32'h0);
    push("rst_irq", O_IRQ, 32'h0);
    push("rst_epc", O_EPC, 32'h0);
    push("rst_timer", O_TIMER, 32'h0);
    step();
    rst = 1'b1;

    // Move Compare away; the Compare write also wins over the count==compare match
    push("cmp_far", O_COMPARE, 32'hFFFF_0000);
    push("timer_clr0", O_TIMER, 32'h0);
    mtc0(5'd11, 3'd0, 32'hFFFF_0000);

    // Delay-slot address error
    push("ds_epc", O_EPC, 32'hBFC0_0100);
    push("ds_bd_code", O_CAUSE, 32'h8000_0010, 32'h8000_007C);
    push("ds_badv", O_BADV, 32'h0000_0003);
    push("ds_exl", O_STATUS, 32'h2, 32'h2);
    raise(EXC_ADEL, 32'hBFC0_0104, 1'b1, 32'h0000_0003);

    // Nested exception with EXL set: EPC/BD hold, code updates, no BadVAddr for Ov
    push("nest_epc", O_EPC, 32'hBFC0_0100);
    push("nest_bd_code", O_CAUSE, 32'h8000_0030, 32'h8000_007C);
    push("nest_exl", O_STATUS, 32'h2, 32'h2);
    push("nest_badv", O_BADV, 32'h0000_0003);
    raise(5'd12, 32'h8000_0000, 1'b0, 32'h1234_5678);

    // ERET with a simultaneous Status write that must be dropped
    except_req = '{valid: 1'b1, eret: 1'b1, code: 5'd0, extra: 32'h0, pc: 32'h0, delayslot: 1'b0};
    push("eret_status", O_STATUS, 32'h0040_0000);
    push("eret_epc", O_EPC, 32'hBFC0_0100);
    mtc0(5'd12, 3'd0, 32'h0000_FF01);
    except_req = '0;

    // Status write mask
    push("status_mask", O_STATUS, 32'h1040_FF03);
    mtc0(5'd12, 3'd0, 32'hFFFF_FFFF);
    mfc0("rd_status", 5'd12, 3'd0, 32'h1040_FF03);

    // Read in the write cycle returns the old value
    wr_en = 1'b1; wr_addr = 5'd12; wr_sel = 3'd0; wr_data = 32'h0000_FF00;
    mfc0("no_bypass", 5'd12, 3'd0, 32'h1040_FF03);
    push("status_im", O_STATUS, 32'h0000_FF00);
    step();
    wr_en = 1'b0;

    // Read-only and unmapped registers, EBase mask
    push("badv_ro", O_BADV, 32'h0000_0003);
    mtc0(5'd8, 3'd0, 32'hDEAD_BEEF);
    mfc0("rd_prid", 5'd15, 3'd0, 32'h0001_8000);
    mfc0("rd_unmapped", 5'd20, 3'd0, 32'h0);
    mfc0("rd_ebase_rst", 5'd15, 3'd1, 32'h8000_0000);
    push("ebase_mask", O_EBASE, 32'hBFFF_F000);
    mtc0(5'd15, 3'd1, 32'hFFFF_FFFF);

    // Cause software bits, then cleared
    push("cause_sw", O_CAUSE, 32'h0080_0300, 32'h0080_0300);
    push("irq_sw", O_IRQ, 32'h03, 32'h03);
    mtc0(5'd13, 3'd0, 32'hFFFF_FFFF);
    push("cause_sw_clr", O_CAUSE, 32'h0, 32'h0080_0300);
    mtc0(5'd13, 3'd0, 32'h0);

    // Hardware interrupt lines
    int_in = 6'b000101;
    push("hw_ip", O_CAUSE, 32'h0000_1400, 32'h0000_FC00);
    push("hw_irq", O_IRQ, 32'h14);
    step();
    int_in = 6'b000000;
    push("hw_ip_clr", O_CAUSE, 32'h0, 32'h0000_FC00);
    push("hw_irq_clr", O_IRQ, 32'h0);
    step();

    // Timer: im = only IP7, Count = 0 then Compare = 5
    mtc0(5'd12, 3'd0, 32'h0000_8000);
    mtc0(5'd9, 3'd0, 32'h0);
    push("tmr_armed", O_TIMER, 32'h0);
    mtc0(5'd11, 3'd0, 32'h5);
    n = 0;
    while (!timer_int && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("tmr_latency", n, 32'd10);
    push("tmr_count", O_COUNT, 32'd5);
    push("tmr_ip7", O_CAUSE, 32'h0000_8000, 32'h0000_8000);
    push("tmr_irq", O_IRQ, 32'h80);
    drain();
    push("tmr_ack", O_TIMER, 32'h0);
    push("tmr_ack_irq", O_IRQ, 32'h0);
    mtc0(5'd11, 3'd0, 32'h0000_0100);

    // Count wrap with the divider
    push("cnt_wr", O_COUNT, 32'hFFFF_FFFF);
    mtc0(5'd9, 3'd0, 32'hFFFF_FFFF);
    push("cnt_hold", O_COUNT, 32'hFFFF_FFFF);
    step();
    push("cnt_wrap", O_COUNT, 32'h0);
    step();

    // Reset mid-operation overrides an exception and an MTC0
    rst = 1'b0;
    except_req = '{valid: 1'b1, eret: 1'b0, code: EXC_ADEL, extra: 32'hFFFF_FFFF,
                   pc: 32'h1234_5678, delayslot: 1'b0};
    push("mid_status", O_STATUS, 32'h0040_0000);
    push("mid_epc", O_EPC, 32'h0);
    push("mid_badv", O_BADV, 32'h0);
    push("mid_compare", O_COMPARE, 32'h0);
    push("mid_ebase", O_EBASE, 32'h8000_0000);
    mtc0(5'd11, 3'd0, 32'h0000_0042);
    except_req = '0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
